nsio_responder: RTL

- IO-space bus responder for the CPU bus: the target end of the CPU's nIOE/nRD/nWR/ADDR/DATO initiator interface.
- Decodes IO accesses to a 256-word window.
- Bridges CPU register accesses to an external stream:
  - 8-deep TX FIFO (CPU writes it, external consumer drains it).
  - 8-deep RX FIFO (external producer fills it, CPU reads it).
  - Reloadable interval timer.
  - Active-low interrupt request.

---
 rtl/nsio_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/nsio_responder.sv
// nsio_responder: IO-space target on the CPU bus bridging register accesses
// to a TX stream FIFO, an RX stream FIFO, a reloadable interval timer and an
// active-low interrupt request.
module nsio_responder #(
    parameter logic [15:0] BASE  = 16'h0000,
    parameter int          DEPTH = 8,
    parameter int          AW    = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        nIOE,
    input  logic        nRD,
    input  logic        nWR,
    input  logic [23:0] ADDR,
    input  logic [23:0] DATO,
    output logic [23:0] DATA,
    output logic        nIRQ,
    output logic [23:0] TXD,
    output logic        TXVALID,
    input  logic        TXREADY,
    input  logic [23:0] RXD,
    input  logic        RXVALID,
    output logic        RXREADY
);

    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Occupancy update shared by both FIFOs: simultaneous inc/dec cancels.
    function automatic logic [AW:0] cnt_next(input logic [AW:0] cnt, input logic inc, input logic dec);
        logic [AW:0] r;
        case ({inc, dec})
            2'b10:   r = cnt + CNT_ONE;
            2'b01:   r = cnt - CNT_ONE;
            default: r = cnt;
        endcase
        return r;
    endfunction

    // Registered state
    logic          nrd_q, nwr_q, rd_arm_q, wr_arm_q;
    logic [23:0]   data_q, data_d;
    logic          nirq_q, nirq_d;
    logic [23:0]   tx_mem_q [DEPTH];
    logic [23:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
    logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [23:0]   reload_q, reload_d, tcnt_q, tcnt_d;
    logic          tflag_q, tflag_d, tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

    // Combinational decode and handshakes
    logic          sel_s, rd_ev_s, wr_ev_s;
    logic [7:0]    reg_s;
    logic          tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic          tx_pop_s, tx_push_req_s, tx_push_s;
    logic          rx_push_s, rx_pop_req_s, rx_pop_s;
    logic          ten_rise_s, tflag_set_s, w1c_s;
    logic [23:0]   status_s, rdata_s;

    // Address select and single-shot strobe events; the arm flags keep a strobe
    // that was already low when reset released from firing until it cycles.
    always_comb begin
        sel_s   = !nIOE && (ADDR[23:8] == BASE);
        reg_s   = ADDR[7:0];
        rd_ev_s = sel_s && !nRD && nWR && nrd_q && rd_arm_q;
        wr_ev_s = sel_s && !nWR && nRD && nwr_q && wr_arm_q;
    end

    // FIFO flags and push/pop qualification
    always_comb begin
        tx_empty_s    = (tx_cnt_q == '0);
        tx_full_s     = (tx_cnt_q == FULL_CNT);
        rx_empty_s    = (rx_cnt_q == '0);
        rx_full_s     = (rx_cnt_q == FULL_CNT);
        tx_pop_s      = !tx_empty_s && TXREADY;
        tx_push_req_s = wr_ev_s && (reg_s == 8'h00);
        tx_push_s     = tx_push_req_s && (!tx_full_s || tx_pop_s);
        rx_push_s     = RXVALID && !rx_full_s;
        rx_pop_req_s  = rd_ev_s && (reg_s == 8'h00);
        rx_pop_s      = rx_pop_req_s && !rx_empty_s;
        tx_cnt_d      = cnt_next(tx_cnt_q, tx_push_s, tx_pop_s);
        rx_cnt_d      = cnt_next(rx_cnt_q, rx_push_s, rx_pop_s);
    end

    // Register read mux
    always_comb begin
        status_s = {17'd0, rx_unf_q, tx_ovf_q, tflag_q, rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};
        case (reg_s)
            8'h00:   rdata_s = rx_empty_s ? 24'd0 : rx_mem_q[rx_rd_ptr_q];
            8'h01:   rdata_s = status_s;
            8'h02:   rdata_s = {21'd0, ctrl_q};
            8'h03:   rdata_s = reload_q;
            default: rdata_s = 24'd0;
        endcase
    end

    // Control/register writes, timer, sticky flags, read data and interrupt
    always_comb begin
        w1c_s      = wr_ev_s && (reg_s == 8'h04);
        ten_rise_s = wr_ev_s && (reg_s == 8'h02) && DATO[2] && !ctrl_q[2];
        if (wr_ev_s && (reg_s == 8'h02)) ctrl_d = DATO[2:0];
        else                             ctrl_d = ctrl_q;
        if (wr_ev_s && (reg_s == 8'h03)) reload_d = DATO;
        else                             reload_d = reload_q;

        tflag_set_s = 1'b0;
        if (ten_rise_s) begin
            tcnt_d = reload_q;
        end else if (ctrl_q[2] && (reload_q != 24'd0)) begin
            if (tcnt_q == 24'd0) begin
                tflag_set_s = 1'b1;
                tcnt_d      = reload_q;
            end else begin
                tcnt_d = tcnt_q - 24'd1;
            end
        end else begin
            tcnt_d = tcnt_q;
        end

        // A set in the same cycle as a clear wins.
        if (tflag_set_s)              tflag_d = 1'b1;
        else if (w1c_s && DATO[4])    tflag_d = 1'b0;
        else                          tflag_d = tflag_q;
        if (tx_push_req_s && !tx_push_s) tx_ovf_d = 1'b1;
        else if (w1c_s && DATO[5])       tx_ovf_d = 1'b0;
        else                             tx_ovf_d = tx_ovf_q;
        if (rx_pop_req_s && rx_empty_s)  rx_unf_d = 1'b1;
        else if (w1c_s && DATO[6])       rx_unf_d = 1'b0;
        else                             rx_unf_d = rx_unf_q;

        if (rd_ev_s)                    data_d = rdata_s;
        else if (sel_s && !nRD && nWR)  data_d = data_q;
        else                            data_d = 24'd0;

        nirq_d = !((ctrl_q[0] && !rx_empty_s) || (ctrl_q[1] && tflag_q));
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            nrd_q <= 1'b1; nwr_q <= 1'b1; rd_arm_q <= 1'b0; wr_arm_q <= 1'b0;
            data_q <= 24'd0; nirq_q <= 1'b1;
            tx_wr_ptr_q <= '0; tx_rd_ptr_q <= '0; tx_cnt_q <= '0;
            rx_wr_ptr_q <= '0; rx_rd_ptr_q <= '0; rx_cnt_q <= '0;
            ctrl_q <= 3'd0; reload_q <= 24'd0; tcnt_q <= 24'd0;
            tflag_q <= 1'b0; tx_ovf_q <= 1'b0; rx_unf_q <= 1'b0;
        end else begin
            nrd_q <= nRD; nwr_q <= nWR;
            rd_arm_q <= rd_arm_q | nRD; wr_arm_q <= wr_arm_q | nWR;
            data_q <= data_d; nirq_q <= nirq_d;
            if (tx_push_s) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_ONE; else tx_wr_ptr_q <= tx_wr_ptr_q;
            if (tx_pop_s)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_ONE; else tx_rd_ptr_q <= tx_rd_ptr_q;
            if (rx_push_s) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_ONE; else rx_wr_ptr_q <= rx_wr_ptr_q;
            if (rx_pop_s)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_ONE; else rx_rd_ptr_q <= rx_rd_ptr_q;
            tx_cnt_q <= tx_cnt_d; rx_cnt_q <= rx_cnt_d;
            ctrl_q <= ctrl_d; reload_q <= reload_d; tcnt_q <= tcnt_d;
            tflag_q <= tflag_d; tx_ovf_q <= tx_ovf_d; rx_unf_q <= rx_unf_d;
        end
    end

    // FIFO storage; contents are only observable through valid pointers
    always_ff @(posedge CLK) begin
        if (tx_push_s) tx_mem_q[tx_wr_ptr_q] <= DATO;
        if (rx_push_s) rx_mem_q[rx_wr_ptr_q] <= RXD;
    end

    assign DATA    = data_q;
    assign nIRQ    = nirq_q;
    assign TXVALID = !tx_empty_s;
    assign TXD     = tx_empty_s ? 24'd0 : tx_mem_q[tx_rd_ptr_q];
    assign RXREADY = !rx_full_s;

endmodule
